// File: rtl/led_frame_scheduler_pkg.sv
// Shared constants, state encodings and frame helpers for the LED array
// configuration-port scheduler.
package led_array_pkg;

  localparam int FRAME_W = 32;
  localparam int CMD_W   = 8;
  localparam int DATA_W  = 24;

  localparam logic [CMD_W-1:0] CMD_NOP   = 8'h00;
  localparam logic [CMD_W-1:0] CMD_WRITE = 8'h03;

  // Serializer bit-level states; ST_GAP is the inter-frame quiet time.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_GAP
  } state_t;

  // Scheduler-level view: waiting, frame on the wire, enforced gap.
  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_XFER,
    SCHED_GAP
  } sched_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [CMD_W-1:0]  cmd,
                                                    input logic [DATA_W-1:0] data);
    return {cmd, data};
  endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Two-requester frame handshake: each requester holds req/frame until its ack pulse.
interface led_frame_scheduler_if #(
  parameter int FRAME_W = led_array_pkg::FRAME_W
);
  logic               req0;
  logic [FRAME_W-1:0] frame0;
  logic               ack0;
  logic               req1;
  logic [FRAME_W-1:0] frame1;
  logic               ack1;

  modport master (output req0, frame0, req1, frame1, input ack0, ack1);
  modport slave  (input req0, frame0, req1, frame1, output ack0, ack1);
endinterface

// File: rtl/led_frame_scheduler_spi_serializer.sv
// Shifts one captured frame MSB-first onto SPI; SCK idles high, data only
// changes with the falling edge, done pulses as ENA_n returns high.
module led_spi_serializer
  import led_array_pkg::*;
#(
  parameter int FRAME_W = led_array_pkg::FRAME_W,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               done,
  output logic               spi_clk,
  output logic               spi_ena_n,
  output logic               spi_data
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(FRAME_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [FRAME_W-1:0] shift_reg, shift_next;
  logic               sck_reg, sck_next;
  logic               ena_n_reg, ena_n_next;
  logic               data_reg, data_next;
  logic               done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      sck_reg     <= 1'b1;
      ena_n_reg   <= 1'b1;
      data_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      sck_reg     <= sck_next;
      ena_n_reg   <= ena_n_next;
      data_reg    <= data_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    sck_next     = sck_reg;
    ena_n_next   = ena_n_reg;
    data_next    = data_reg;
    done_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          shift_next   = frame;
          data_next    = frame[FRAME_W-1];
          sck_next     = 1'b0;
          ena_n_next   = 1'b0;
          div_cnt_next = '0;
          bit_cnt_next = BIT_LAST;
          state_next   = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          sck_next     = 1'b1;
          state_next   = ST_SHIFT_HI;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          if (bit_cnt_reg == '0) begin
            // Last bit: release the frame but leave SCK at its idle-high level.
            ena_n_next = 1'b1;
            data_next  = 1'b0;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg - BIT_W'(1);
            shift_next   = {shift_reg[FRAME_W-2:0], 1'b0};
            data_next    = shift_reg[FRAME_W-2];
            sck_next     = 1'b0;
            state_next   = ST_SHIFT_LO;
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign done      = done_reg;
  assign spi_clk   = sck_reg;
  assign spi_ena_n = ena_n_reg;
  assign spi_data  = data_reg;

endmodule

// File: rtl/led_frame_scheduler.sv
// Round-robin shares the LED array SPI configuration port between the host and
// the pattern engine, enforces an inter-frame gap and gates the array enable.
module led_frame_scheduler
  import led_array_pkg::*;
#(
  parameter int FRAME_W = led_array_pkg::FRAME_W,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET_n,
  led_frame_scheduler_if.slave  req_if,
  input  logic                  i_run,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_done_id,
  output logic                  o_SPI_CLK,
  output logic                  o_SPI_ENA_n,
  output logic                  o_SPI_DATA,
  output logic                  o_ENA_p
);

  localparam int GAP_W = $clog2(GAP_CYC) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  sched_t             sched_reg, sched_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               ack0_reg, ack0_next;
  logic               ack1_reg, ack1_next;
  logic               busy_reg, busy_next;
  logic               last_grant_reg, last_grant_next;
  logic               active_id_reg, active_id_next;
  logic               configured_reg, configured_next;
  logic               ena_p_reg, ena_p_next;
  logic               grant_id;
  logic               ser_start;
  logic               ser_done;
  logic [FRAME_W-1:0] ser_frame;

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      sched_reg      <= SCHED_IDLE;
      gap_cnt_reg    <= '0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      last_grant_reg <= 1'b1;
      active_id_reg  <= 1'b0;
      configured_reg <= 1'b0;
      ena_p_reg      <= 1'b0;
    end else begin
      sched_reg      <= sched_next;
      gap_cnt_reg    <= gap_cnt_next;
      ack0_reg       <= ack0_next;
      ack1_reg       <= ack1_next;
      busy_reg       <= busy_next;
      last_grant_reg <= last_grant_next;
      active_id_reg  <= active_id_next;
      configured_reg <= configured_next;
      ena_p_reg      <= ena_p_next;
    end
  end

  always_comb begin
    sched_next      = sched_reg;
    gap_cnt_next    = gap_cnt_reg;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    busy_next       = busy_reg;
    last_grant_next = last_grant_reg;
    active_id_next  = active_id_reg;
    ser_start       = 1'b0;
    // On contention the requester that was not served last wins.
    grant_id        = (req_if.req0 && req_if.req1) ? ~last_grant_reg : req_if.req1;
    ser_frame       = grant_id ? req_if.frame1 : req_if.frame0;
    // Folding ser_done in lets the enable rise on the cycle right after o_done.
    configured_next = configured_reg | ser_done;
    ena_p_next      = i_run & (configured_reg | ser_done);
    case (sched_reg)
      SCHED_IDLE: begin
        if (req_if.req0 || req_if.req1) begin
          ser_start       = 1'b1;
          ack0_next       = ~grant_id;
          ack1_next       = grant_id;
          busy_next       = 1'b1;
          last_grant_next = grant_id;
          active_id_next  = grant_id;
          sched_next      = SCHED_XFER;
        end
      end
      SCHED_XFER: begin
        if (ser_done) begin
          // The o_done cycle already counts as the first gap cycle.
          if (GAP_CYC <= 1) begin
            busy_next  = 1'b0;
            sched_next = SCHED_IDLE;
          end else begin
            gap_cnt_next = GAP_W'(1);
            sched_next   = SCHED_GAP;
          end
        end
      end
      SCHED_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          busy_next    = 1'b0;
          sched_next   = SCHED_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      default: sched_next = SCHED_IDLE;
    endcase
  end

  led_spi_serializer #(
    .FRAME_W (FRAME_W),
    .CLK_DIV (CLK_DIV)
  ) u_serializer (
    .clk       (i_CLK),
    .rst_n     (i_RESET_n),
    .start     (ser_start),
    .frame     (ser_frame),
    .done      (ser_done),
    .spi_clk   (o_SPI_CLK),
    .spi_ena_n (o_SPI_ENA_n),
    .spi_data  (o_SPI_DATA)
  );

  assign req_if.ack0 = ack0_reg;
  assign req_if.ack1 = ack1_reg;
  assign o_busy      = busy_reg;
  assign o_done      = ser_done;
  assign o_done_id   = active_id_reg;
  assign o_ENA_p     = ena_p_reg;

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Single-clock controller that shares the LED array's SPI configuration port between two frame requesters (host command path, pattern/animation engine).
- Arbitrates round-robin, serialises the granted 32-bit frame (8-bit command + 24-bit data, MSB first) onto the array's SPI lines, and then raises the array enable.
- Sits between the system clock domain and LED_ARRAY_top's i_SPI_CLK/i_SPI_ENA_n/i_SPI_DATA/i_ENA_p inputs.

Parameters:
- FRAME_W, 32, frame length in bits (command 8 + data 24).
- CLK_DIV, 4, system clocks per SPI half-period (>=1).
- GAP_CYC, 8, minimum system clocks with o_SPI_ENA_n high between frames (>=1).

Ports:
- i_CLK  in  1  system clock, rising edge.
- i_RESET_n  in  1  asynchronous active-low reset.
- i_req0  in  1  requester 0 (host) frame request; hold until o_ack0.
- i_frame0  in  FRAME_W  requester 0 frame; stable while i_req0 high.
- o_ack0  out  1  one-cycle pulse: frame0 captured.
- i_req1  in  1  requester 1 (pattern engine) frame request.
- i_frame1  in  FRAME_W  requester 1 frame.
- o_ack1  out  1  one-cycle pulse: frame1 captured.
- i_run  in  1  array output enable request.
- o_busy  out  1  high from capture through end of GAP.
- o_done  out  1  one-cycle pulse at end of a frame's last SCK high phase.
- o_done_id  out  1  requester index of the frame reported by o_done.
- o_SPI_CLK  out  1  SPI clock to array; idles high.
- o_SPI_ENA_n  out  1  SPI frame enable, active low.
- o_SPI_DATA  out  1  SPI data, MSB first.
- o_ENA_p  out  1  array enable.

Behaviour:
- Reset (async, any time including mid-frame): o_SPI_CLK=1, o_SPI_ENA_n=1, o_SPI_DATA=0, o_ENA_p=0, o_ack*=0, o_busy=0, o_done=0, o_done_id=0, state=IDLE, last-grant=1 (requester 0 wins first), configured flag=0. The partial frame is discarded.
- States: IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO, or GAP after bit 0) -> IDLE.
- IDLE:
  - On an edge with any i_reqN high, grant per arbitration.
  - Same edge: pulse o_ackN, capture frame into the shift register, o_SPI_ENA_n=0, o_SPI_CLK=0, o_SPI_DATA=frame[FRAME_W-1], o_busy=1. Enter SHIFT_LO.
- Arbitration:
  - Only one request: that requester wins.
  - Both requests: the requester not granted last wins.
  - Last-grant updates on every grant.
- SHIFT_LO: hold CLK_DIV cycles, then o_SPI_CLK=1 and enter SHIFT_HI. The array samples on this rising edge.
- SHIFT_HI: hold CLK_DIV cycles.
  - Bits remaining: o_SPI_CLK=0, o_SPI_DATA=next lower bit (data changes only with the falling edge), enter SHIFT_LO.
  - Bit 0 done: o_SPI_ENA_n=1, o_SPI_DATA=0, o_SPI_CLK stays 1, pulse o_done with o_done_id, set configured flag, enter GAP.
- Frame timing: o_SPI_ENA_n low for exactly 2*CLK_DIV*FRAME_W cycles (256 at defaults).
- GAP: GAP_CYC cycles, o_busy=1, requests ignored; then IDLE, o_busy=0.
  - Back-to-back frames therefore start GAP_CYC+1 cycles after o_done at the earliest.
- Requests arriving while busy wait; no ack is issued. A request dropped before ack is simply not served.
- o_ENA_p: registered; next-cycle value = i_run AND configured flag.
  - Rises no earlier than the cycle after the first o_done.
  - Falls one cycle after i_run falls.
  - Unaffected by later frames.
- Counters:
  - Divider counter width clog2(CLK_DIV)+1.
  - Bit counter width clog2(FRAME_W)+1.
  - Neither counter wraps outside its state.

Decomposition:
- Package led_array_pkg holds:
  - FRAME_W=32, CMD_W=8, DATA_W=24.
  - State encoding (IDLE, SHIFT_LO, SHIFT_HI, GAP).
  - Command constants, e.g. CMD_WRITE=8'h03.
- One sub-module: led_spi_serializer (shift register, divider, bit counter, SPI pins; start/frame in, done out).
- The arbiter, GAP timer and o_ENA_p logic stay in the top level.

Test Plan:
- Single frame: after reset, i_req0=1 with i_frame0=32'h0300_0100 -> o_ack0 pulse; 32 bits sampled on o_SPI_CLK rising edges decode to 32'h0300_0100; o_SPI_ENA_n low exactly 256 cycles; o_done=1 with o_done_id=0.
- Round-robin: i_req0 and i_req1 both held with frames 32'h0300_00AA and 32'h0300_0055 -> frame0 sent first, frame1 second, gap of >=8 cycles between them; re-raise both -> frame0 first again; raise only i_req1 twice -> served both times.
- Enable gating: i_run=1 before any frame -> o_ENA_p stays 0; first o_done -> o_ENA_p=1 on the next cycle; i_run=0 -> o_ENA_p=0 one cycle later.
- Reset mid-frame: assert i_RESET_n=0 at bit 15 -> same time step: o_SPI_ENA_n=1, o_SPI_CLK=1, o_SPI_DATA=0, o_ENA_p=0; after release the pending i_req1 is granted first.
- Busy blocking: raise i_req1 during the frame0 transfer -> no o_ack1 until GAP completes; o_ack1 arrives exactly GAP_CYC+1 cycles after o_done.
- CLK_DIV=1 build: frame 32'hFFFF_FFFF -> o_SPI_ENA_n low 64 cycles, o_SPI_DATA=1 for all 32 bits.
